// File: rtl/pc_pkg.sv
// Shared types, step constants and alignment helper
// for the fetch program-counter unit.
package pc_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } pc_state_t;

  localparam int STEP2 = 2;
  localparam int STEP4 = 4;

  function automatic logic is_misaligned(
    input logic [63:0] addr,
    input logic        compressed
  );
    if (compressed)
      return addr[0];
    else
      return addr[1] | addr[0];
  endfunction

endpackage

// File: rtl/pc_align_check.sv
// Combinational misalignment detector
// for redirect targets.
module pc_align_check
  import pc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit COMPRESSED = 1'b0
) (
  input  logic [XLEN-1:0] addr,
  output logic            misaligned
);

  assign misaligned = is_misaligned(64'(addr), COMPRESSED);

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with sequential step,
// redirect, and misaligned-target trap.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = '0,
  parameter bit              COMPRESSED   = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            load,
  input  logic [XLEN-1:0] target,
  input  logic            inst_len,
  input  logic            trap,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_seq,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("pc_unit: XLEN must be 32 or 64");
  end
  if (is_misaligned(64'(RESET_VECTOR), COMPRESSED)) begin : g_bad_rv
    $error("pc_unit: RESET_VECTOR misaligned");
  end
  if (is_misaligned(64'(TRAP_VECTOR), COMPRESSED)) begin : g_bad_tv
    $error("pc_unit: TRAP_VECTOR misaligned");
  end

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fault_addr_q, fault_addr_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] step;
  logic            tgt_mis;

  pc_align_check #(
    .XLEN       (XLEN),
    .COMPRESSED (COMPRESSED)
  ) u_align (
    .addr       (target),
    .misaligned (tgt_mis)
  );

  assign step   = (COMPRESSED && inst_len) ? XLEN'(STEP2)
                                           : XLEN'(STEP4);
  assign pc_seq = pc_q + step;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_addr_d = fault_addr_q;
    if (trap) begin
      pc_d    = TRAP_VECTOR;
      state_d = RUN;
    end else if (state_q == RUN && !stall) begin
      if (load && tgt_mis) begin
        fault_addr_d = target;
        state_d      = FAULT;
      end else if (load) begin
        pc_d = target;
      end else begin
        pc_d = pc_seq;
      end
    end
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_VECTOR;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign pc         = pc_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

`ifdef FORMAL
  logic past_ok = 1'b0;
  always_ff @(posedge clk) past_ok <= 1'b1;

  always_comb begin
    assert (!is_misaligned(64'(pc_q), COMPRESSED));
    assert (fault_q == (state_q == FAULT));
  end

  always_ff @(posedge clk) begin
    if (past_ok && !$past(reset)) begin
      if ($past(trap))
        assert (pc_q == TRAP_VECTOR && !fault_q);
      else if ($past(state_q) == FAULT)
        assert ($stable(pc_q) && $stable(fault_addr_q) && fault_q);
      else if ($past(stall))
        assert ($stable(pc_q) && !fault_q);
      else if ($past(load) && $past(tgt_mis))
        assert ($stable(pc_q) && fault_q
                && fault_addr_q == $past(target));
      else if ($past(load))
        assert (pc_q == $past(target));
      else
        assert (pc_q == $past(pc_seq));
    end
    if (past_ok && $past(reset))
      assert (pc_q == RESET_VECTOR && !fault_q && fault_addr_q == '0);
  end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit in
// 4-byte (u0) and compressed (u1) configurations.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        s0, l0, il0, tr0;
  logic [31:0] t0;
  logic [31:0] pc0, seq0, fa0;
  logic        f0;
  logic        s1, l1, il1, tr1;
  logic [31:0] t1;
  logic [31:0] pc1, seq1, fa1;
  logic        f1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h100),
    .TRAP_VECTOR  (32'h80),
    .COMPRESSED   (1'b0)
  ) u0 (
    .clk        (clk),
    .reset      (reset),
    .stall      (s0),
    .load       (l0),
    .target     (t0),
    .inst_len   (il0),
    .trap       (tr0),
    .pc         (pc0),
    .pc_seq     (seq0),
    .fault      (f0),
    .fault_addr (fa0)
  );

  pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0),
    .TRAP_VECTOR  (32'h40),
    .COMPRESSED   (1'b1)
  ) u1 (
    .clk        (clk),
    .reset      (reset),
    .stall      (s1),
    .load       (l1),
    .target     (t1),
    .inst_len   (il1),
    .trap       (tr1),
    .pc         (pc1),
    .pc_seq     (seq1),
    .fault      (f1),
    .fault_addr (fa1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s0 = 0; l0 = 0; il0 = 0; tr0 = 0; t0 = '0;
    s1 = 0; l1 = 0; il1 = 0; tr1 = 0; t1 = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (pc0 !== 32'h100) begin
      n_fail++;
      $display("FAIL reset_pc0 got %h want %h", pc0, 32'h100);
    end
    n_chk++;
    if (f0 !== 1'b0 || fa0 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_fault0 got %b/%h want 0/0", f0, fa0);
    end
    n_chk++;
    if (pc1 !== 32'h0 || f1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_u1 got %h/%b want 0/0", pc1, f1);
    end
    n_chk++;
    if (seq0 !== 32'h104) begin
      n_fail++;
      $display("FAIL reset_seq0 got %h want %h", seq0, 32'h104);
    end
  endtask

  task automatic test_seq4();
    logic [31:0] exp [3];
    exp[0] = 32'h104; exp[1] = 32'h108; exp[2] = 32'h10C;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      il0 = (i == 1);
      tick();
      n_chk++;
      if (pc0 !== exp[i] || f0 !== 1'b0) begin
        n_fail++;
        $display("FAIL seq4_%0d got %h/%b want %h/0",
                 i, pc0, f0, exp[i]);
      end
    end
  endtask

  task automatic test_compressed();
    logic [31:0] exp [3];
    logic        len [3];
    exp[0] = 32'h2; exp[1] = 32'h6; exp[2] = 32'h8;
    len[0] = 1;     len[1] = 0;     len[2] = 1;
    do_reset();
    il1 = 1'b1;
    #1;
    n_chk++;
    if (seq1 !== 32'h2) begin
      n_fail++;
      $display("FAIL c_seq got %h want %h", seq1, 32'h2);
    end
    for (int i = 0; i < 3; i++) begin
      il1 = len[i];
      tick();
      n_chk++;
      if (pc1 !== exp[i]) begin
        n_fail++;
        $display("FAIL c_step_%0d got %h want %h", i, pc1, exp[i]);
      end
    end
    il1 = 0; l1 = 1; t1 = 32'h6;
    tick();
    n_chk++;
    if (pc1 !== 32'h6 || f1 !== 1'b0) begin
      n_fail++;
      $display("FAIL c_load2 got %h/%b want 6/0", pc1, f1);
    end
    t1 = 32'h3;
    tick();
    l1 = 0;
    n_chk++;
    if (pc1 !== 32'h6 || f1 !== 1'b1 || fa1 !== 32'h3) begin
      n_fail++;
      $display("FAIL c_fault got %h/%b/%h want 6/1/3", pc1, f1, fa1);
    end
    tr1 = 1;
    tick();
    tr1 = 0;
    n_chk++;
    if (pc1 !== 32'h40 || f1 !== 1'b0) begin
      n_fail++;
      $display("FAIL c_trap got %h/%b want 40/0", pc1, f1);
    end
  endtask

  task automatic test_load_stall();
    logic [31:0] exp [4];
    logic        stl [4];
    exp[0] = 32'h2000; exp[1] = 32'h2000;
    exp[2] = 32'h2000; exp[3] = 32'h2004;
    stl[0] = 0; stl[1] = 1; stl[2] = 1; stl[3] = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      l0 = (i == 0); t0 = 32'h2000; s0 = stl[i];
      tick();
      n_chk++;
      if (pc0 !== exp[i]) begin
        n_fail++;
        $display("FAIL ldst_%0d got %h want %h", i, pc0, exp[i]);
      end
    end
    s0 = 1; l0 = 1; t0 = 32'h3000;
    tick();
    s0 = 0; l0 = 0;
    tick();
    n_chk++;
    if (pc0 !== 32'h2008) begin
      n_fail++;
      $display("FAIL stall_load_lost got %h want %h", pc0, 32'h2008);
    end
  endtask

  task automatic test_fault();
    do_reset();
    l0 = 1; t0 = 32'h1002;
    tick();
    n_chk++;
    if (f0 !== 1'b1 || fa0 !== 32'h1002 || pc0 !== 32'h100) begin
      n_fail++;
      $display("FAIL fault_enter got %b/%h/%h want 1/1002/100",
               f0, fa0, pc0);
    end
    t0 = 32'h4000;
    tick();
    l0 = 0; s0 = 1;
    tick();
    s0 = 0;
    tick();
    n_chk++;
    if (f0 !== 1'b1 || fa0 !== 32'h1002 || pc0 !== 32'h100) begin
      n_fail++;
      $display("FAIL fault_hold got %b/%h/%h want 1/1002/100",
               f0, fa0, pc0);
    end
    tr0 = 1;
    tick();
    tr0 = 0;
    n_chk++;
    if (pc0 !== 32'h80 || f0 !== 1'b0 || fa0 !== 32'h1002) begin
      n_fail++;
      $display("FAIL fault_trap got %h/%b/%h want 80/0/1002",
               pc0, f0, fa0);
    end
    tick();
    n_chk++;
    if (pc0 !== 32'h84) begin
      n_fail++;
      $display("FAIL post_trap got %h want %h", pc0, 32'h84);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    l0 = 1; t0 = 32'hFFFF_FFFC;
    tick();
    l0 = 0;
    n_chk++;
    if (pc0 !== 32'hFFFF_FFFC || seq0 !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_pre got %h/%h want fffffffc/0", pc0, seq0);
    end
    tick();
    n_chk++;
    if (pc0 !== 32'h0 || f0 !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap got %h/%b want 0/0", pc0, f0);
    end
  endtask

  task automatic test_trap_vs_load();
    do_reset();
    l0 = 1; t0 = 32'h1001; tr0 = 1;
    tick();
    l0 = 0; tr0 = 0;
    n_chk++;
    if (pc0 !== 32'h80 || f0 !== 1'b0 || fa0 !== 32'h0) begin
      n_fail++;
      $display("FAIL trap_win got %h/%b/%h want 80/0/0", pc0, f0, fa0);
    end
  endtask

  task automatic test_reset_in_fault();
    do_reset();
    l0 = 1; t0 = 32'h1002;
    tick();
    l0 = 0;
    n_chk++;
    if (f0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rf_enter got %b want 1", f0);
    end
    reset = 1; tr0 = 0;
    tick();
    reset = 0;
    n_chk++;
    if (pc0 !== 32'h100 || f0 !== 1'b0 || fa0 !== 32'h0) begin
      n_fail++;
      $display("FAIL rf_reset got %h/%b/%h want 100/0/0", pc0, f0, fa0);
    end
    s0 = 1;
    tick();
    reset = 1;
    tick();
    reset = 0; s0 = 0;
    n_chk++;
    if (pc0 !== 32'h100) begin
      n_fail++;
      $display("FAIL rs_reset got %h want %h", pc0, 32'h100);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_seq4();
    test_compressed();
    test_load_stall();
    test_fault();
    test_wrap();
    test_trap_vs_load();
    test_reset_in_fault();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
